// File: rtl/tis_any_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tis_defs (package)
// Purpose  : Shared definitions for the tis100 node link logic: neighbour
//            port indices, default word width and arbiter FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package tis_defs;

  // Neighbour link indices as seen from a node
  localparam int PORT_LEFT  = 0;
  localparam int PORT_RIGHT = 1;
  localparam int PORT_UP    = 2;
  localparam int PORT_DOWN  = 3;

  // Port index width (four neighbours) and node word width
  localparam int PORT_IDX_W = 2;
  localparam int TIS_DATA_W = 11;

  // ANY/LAST read arbiter states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_HOLD  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/tis_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : tis_rr_picker
// Purpose  : Combinational picker: eligible mask + start pointer + mode ->
//            one-hot winner and its index. Fixed priority (lowest index) when
//            rr_mode = 0, otherwise first eligible index at/after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module tis_rr_picker #(
  parameter int NPORTS = 4,
  parameter int IDXW   = 2
) (
  input  logic [NPORTS-1:0] eligible,
  input  logic [IDXW-1:0]   ptr,
  input  logic              rr_mode,
  output logic [NPORTS-1:0] grant,
  output logic [IDXW-1:0]   grant_idx,
  output logic              found
);

  int              w_start;
  logic [IDXW-1:0] w_j;

  // Scan ports starting at the pointer (or 0) and keep the first eligible one
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    w_j       = '0;
    w_start   = rr_mode ? int'(ptr) : 0;
    for (int k = 0; k < NPORTS; k++) begin
      w_j = IDXW'((w_start + k) % NPORTS);
      if (!found && eligible[w_j]) begin
        found      = 1'b1;
        grant[w_j] = 1'b1;
        grant_idx  = w_j;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tis_any_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tis_any_port_arbiter
// Purpose  : Resolves ANY/LAST port reads for a tis100 node. Picks one
//            neighbour offer, hands its word to the node, acks only that
//            writer and records the direction for later LAST reads.
// Revision : 1.0 - initial release
// ============================================================================
module tis_any_port_arbiter
  import tis_defs::*;
#(
  parameter int NPORTS = 4,
  parameter int DATA_W = TIS_DATA_W,
  parameter int RR     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        src_valid,
  input  logic [NPORTS*DATA_W-1:0] src_data,
  output logic [NPORTS-1:0]        src_ack,
  input  logic                     rd_req,
  input  logic                     rd_last,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic [1:0]               rd_port,
  output logic                     last_valid,
  output logic [1:0]               last_port
);

  localparam logic RR_MODE = (RR != 0);

  arb_state_t              r_state;
  logic [PORT_IDX_W-1:0]   r_win;
  logic [NPORTS-1:0]       r_win_oh;
  logic [PORT_IDX_W-1:0]   r_ptr;
  logic [DATA_W-1:0]       r_word;
  logic                    r_nil;
  logic                    r_any;

  logic [NPORTS-1:0]       w_last_oh;
  logic [NPORTS-1:0]       w_elig;
  logic [NPORTS-1:0]       w_grant;
  logic [PORT_IDX_W-1:0]   w_idx;
  logic                    w_found;
  logic                    w_nil;
  logic [DATA_W-1:0]       w_word;

  // Eligible set: every offer for ANY, only the recorded direction for LAST
  always_comb begin
    w_last_oh = NPORTS'(1) << last_port;
    w_nil     = rd_last & ~last_valid;
    if (!rd_last)
      w_elig = src_valid;
    else if (last_valid)
      w_elig = src_valid & w_last_oh;
    else
      w_elig = '0;
    w_word = src_data[w_idx*DATA_W +: DATA_W];
  end

  tis_rr_picker #(
    .NPORTS (NPORTS),
    .IDXW   (PORT_IDX_W)
  ) u_picker (
    .eligible  (w_elig),
    .ptr       (r_ptr),
    .rr_mode   (RR_MODE),
    .grant     (w_grant),
    .grant_idx (w_idx),
    .found     (w_found)
  );

  // Grant FSM: capture the winner in IDLE, pulse the result in SERVE, and
  // wait in HOLD until the node releases its request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_win      <= '0;
      r_win_oh   <= '0;
      r_ptr      <= '0;
      r_word     <= '0;
      r_nil      <= 1'b0;
      r_any      <= 1'b0;
      src_ack    <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_port    <= '0;
      last_valid <= 1'b0;
      last_port  <= '0;
    end else begin
      rd_valid <= 1'b0;
      src_ack  <= '0;
      case (r_state)
        ST_IDLE: begin
          if (rd_req) begin
            if (w_nil) begin
              r_nil   <= 1'b1;
              r_any   <= 1'b0;
              r_word  <= '0;
              r_state <= ST_SERVE;
            end else if (w_found) begin
              r_nil    <= 1'b0;
              r_any    <= ~rd_last;
              r_win    <= w_idx;
              r_win_oh <= w_grant;
              r_word   <= w_word;
              r_state  <= ST_SERVE;
            end
          end
        end
        ST_SERVE: begin
          rd_valid <= 1'b1;
          rd_data  <= r_word;
          if (!r_nil) begin
            rd_port <= r_win;
            src_ack <= r_win_oh;
            if (r_any) begin
              last_port  <= r_win;
              last_valid <= 1'b1;
              r_ptr      <= (r_win == PORT_IDX_W'(NPORTS - 1)) ? '0 : r_win + 1'b1;
            end
          end
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!rd_req)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tis_any_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tis_any_port_arbiter
// Purpose  : Directed bench for the ANY/LAST arbiter; one fixed-priority and
//            one round-robin instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tis_any_port_arbiter;
  import tis_defs::*;

  localparam int DW = 11;

  logic clk = 1'b0;
  logic rst_n;

  logic [3:0]    sv0, ack0, sv1, ack1;
  logic [4*DW-1:0] sd0, sd1;
  logic          req0, last0, rv0, lv0, req1, last1, rv1, lv1;
  logic [DW-1:0] rdat0, rdat1;
  logic [1:0]    rport0, lp0, rport1, lp1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tis_any_port_arbiter #(.NPORTS(4), .DATA_W(DW), .RR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .src_valid(sv0), .src_data(sd0), .src_ack(ack0),
    .rd_req(req0), .rd_last(last0), .rd_valid(rv0), .rd_data(rdat0),
    .rd_port(rport0), .last_valid(lv0), .last_port(lp0));

  tis_any_port_arbiter #(.NPORTS(4), .DATA_W(DW), .RR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .src_valid(sv1), .src_data(sd1), .src_ack(ack1),
    .rd_req(req1), .rd_last(last1), .rd_valid(rv1), .rd_data(rdat1),
    .rd_port(rport1), .last_valid(lv1), .last_port(lp1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    sv0 = '0; sd0 = '0; req0 = 1'b0; last0 = 1'b0;
    sv1 = '0; sd1 = '0; req1 = 1'b0; last1 = 1'b0;
    repeat (3) tick();
    chk("rst_rd_valid", rv0, 0);
    chk("rst_rd_data", rdat0, 0);
    chk("rst_rd_port", rport0, 0);
    chk("rst_src_ack", ack0, 0);
    chk("rst_last_valid", lv0, 0);
    chk("rst_last_port", lp0, 0);
    chk("rst_rr_valid", rv1, 0);
    rst_n = 1'b1;

    // NIL read straight after reset
    req0 = 1'b1; last0 = 1'b1;
    tick();
    chk("nil_lat1", rv0, 0);
    tick();
    chk("nil_valid", rv0, 1);
    chk("nil_data", rdat0, 0);
    chk("nil_ack", ack0, 0);
    chk("nil_last_valid", lv0, 0);
    req0 = 1'b0; last0 = 1'b0;
    tick();
    chk("nil_pulse_end", rv0, 0);

    // Fixed priority: RIGHT and DOWN offer, RIGHT wins; data captured at grant
    sv0 = 4'b1010;
    sd0[PORT_RIGHT*DW +: DW] = 11'd5;
    sd0[PORT_DOWN*DW +: DW]  = -11'sd7;
    req0 = 1'b1;
    tick();
    chk("fp_lat1", rv0, 0);
    sd0[PORT_RIGHT*DW +: DW] = 11'd77;
    sv0 = 4'b0000;
    tick();
    chk("fp_valid", rv0, 1);
    chk("fp_data", rdat0, 5);
    chk("fp_port", rport0, 1);
    chk("fp_ack", ack0, 4'b0010);
    chk("fp_last_valid", lv0, 1);
    chk("fp_last_port", lp0, 1);
    tick();
    chk("fp_hold_valid", rv0, 0);
    chk("fp_hold_ack", ack0, 0);
    req0 = 1'b0;
    tick();

    // LAST read: only RIGHT may be taken
    sv0 = 4'b0011;
    sd0[PORT_LEFT*DW +: DW]  = 11'd9;
    sd0[PORT_RIGHT*DW +: DW] = 11'd3;
    req0 = 1'b1; last0 = 1'b1;
    tick();
    tick();
    chk("last_valid_pulse", rv0, 1);
    chk("last_data", rdat0, 3);
    chk("last_ack", ack0, 4'b0010);
    chk("last_port_kept", lp0, 1);
    req0 = 1'b0;
    tick();
    sv0 = 4'b0001;
    req0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("last_blocked_valid", rv0, 0);
      chk("last_blocked_ack", ack0, 0);
    end
    req0 = 1'b0; last0 = 1'b0;
    tick();
    chk("last_drop_valid", rv0, 0);

    // Blocking ANY read, then UP offers
    sv0 = 4'b0000;
    req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("blk_valid", rv0, 0);
      chk("blk_ack", ack0, 0);
    end
    sv0 = 4'b0100;
    sd0[PORT_UP*DW +: DW] = 11'd100;
    tick();
    chk("blk_lat1", rv0, 0);
    tick();
    chk("blk_valid_pulse", rv0, 1);
    chk("blk_data", rdat0, 100);
    chk("blk_ack_up", ack0, 4'b0100);
    chk("blk_port", rport0, 2);
    chk("blk_last_port", lp0, 2);
    req0 = 1'b0; sv0 = 4'b0000;
    tick();

    // Round-robin: four offers, five reads
    sv1 = 4'b1111;
    sd1[PORT_LEFT*DW +: DW]  = 11'd10;
    sd1[PORT_RIGHT*DW +: DW] = 11'd11;
    sd1[PORT_UP*DW +: DW]    = 11'd12;
    sd1[PORT_DOWN*DW +: DW]  = 11'd13;
    for (int i = 0; i < 5; i++) begin
      req1 = 1'b1;
      tick();
      tick();
      chk("rr_valid", rv1, 1);
      chk("rr_port", rport1, i % 4);
      chk("rr_ack", ack1, 32'd1 << (i % 4));
      chk("rr_data", rdat1, 10 + (i % 4));
      tick();
      chk("rr_hold_ack", ack1, 0);
      chk("rr_hold_valid", rv1, 0);
      req1 = 1'b0;
      tick();
    end
    chk("rr_last_valid", lv1, 1);
    chk("rr_last_port", lp1, 0);

    // Reset while the grant is in flight
    sv0 = 4'b0001;
    sd0[PORT_LEFT*DW +: DW] = 11'd21;
    req0 = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_last_valid", lv0, 0);
    chk("arst_last_port", lp0, 0);
    chk("arst_rd_port", rport0, 0);
    tick();
    chk("arst_valid", rv0, 0);
    chk("arst_ack", ack0, 0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", rv0, 0);
    chk("post_rst_ack", ack0, 0);
    tick();
    chk("post_rst_grant", rv0, 1);
    chk("post_rst_data", rdat0, 21);
    chk("post_rst_ack1", ack0, 4'b0001);
    req0 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
